// File: rtl/ysyx_041461_booth_iter_mul_if.sv
// Handshake bundle for the iterative Booth multiplier: request side, response side and flush.
interface ysyx_041461_booth_iter_mul_if #(
  parameter int unsigned XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output flush, in_valid, in_op, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  flush, in_valid, in_op, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/ysyx_041461_booth_iter_mul.sv
// Iterative radix-4 Booth multiplier for RV M-extension multiplies (MUL/MULH/MULHSU/MULHU/MULW).
// Retires two multiplier bits per cycle into a 2*XLEN accumulator; ready/valid on both sides.
module ysyx_041461_booth_iter_mul #(
  parameter int unsigned XLEN = 64
) (
  input logic                           clk,
  input logic                           rst,
  ysyx_041461_booth_iter_mul_if.slave   bus
);
  localparam int unsigned W2    = 2 * XLEN;
  localparam int unsigned YW    = XLEN + 3;
  localparam int unsigned NFull = XLEN / 2 + 1;
  localparam int unsigned NWord = XLEN / 4 + 1;
  localparam int unsigned CW    = $clog2(NFull + 1);
  localparam int unsigned HW    = XLEN / 2;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpMulw   = 3'b100;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q;
  logic [W2-1:0]   x_q;
  logic [W2-1:0]   acc_q;
  logic [YW-1:0]   y_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            s1_signed, s2_signed;
  logic [XLEN-1:0] a_src, b_src;
  logic [W2-1:0]   x_ext;
  logic [YW-1:0]   y_ext;
  logic [W2-1:0]   pp;
  logic [CW-1:0]   last_cnt;

  assign accept = (state_q == StIdle) && bus.in_valid && !bus.flush;

  // Operand extension; extending X all the way to 2*XLEN keeps the accumulator exact mod 2^W2.
  always_comb begin
    a_src     = bus.in_src1;
    b_src     = bus.in_src2;
    s1_signed = 1'b0;
    s2_signed = 1'b0;
    case (bus.in_op)
      OpMul, OpMulh: begin
        s1_signed = 1'b1;
        s2_signed = 1'b1;
      end
      OpMulhsu: s1_signed = 1'b1;
      OpMulw: begin
        s1_signed = 1'b1;
        s2_signed = 1'b1;
        a_src     = {{HW{bus.in_src1[HW-1]}}, bus.in_src1[HW-1:0]};
        b_src     = {{HW{bus.in_src2[HW-1]}}, bus.in_src2[HW-1:0]};
      end
      default: ;
    endcase
  end

  assign x_ext = s1_signed ? {{XLEN{a_src[XLEN-1]}}, a_src} : {{XLEN{1'b0}}, a_src};
  // Multiplier carries an implicit b[-1]=0 in its LSB so y_q[2:0] is always the current triplet.
  assign y_ext = {(s2_signed ? {2{b_src[XLEN-1]}} : 2'b00), b_src, 1'b0};

  always_comb begin
    pp = '0;
    unique case (y_q[2:0])
      3'b001, 3'b010: pp = x_q;
      3'b011:         pp = x_q << 1;
      3'b100:         pp = -(x_q << 1);
      3'b101, 3'b110: pp = -x_q;
      default:        pp = '0;
    endcase
  end

  assign last_cnt = (op_q == OpMulw) ? CW'(NWord - 1) : CW'(NFull - 1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StCalc;
      StCalc:  if (cnt_q == last_cnt) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpMul;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= bus.in_op;
        x_q   <= x_ext;
        y_q   <= y_ext;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == StCalc) begin
        acc_q <= acc_q + pp;
        x_q   <= x_q << 2;
        y_q   <= {{2{y_q[YW-1]}}, y_q[YW-1:2]};
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);

  always_comb begin
    bus.out_result = '0;
    case (op_q)
      OpMul:                       bus.out_result = acc_q[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:   bus.out_result = acc_q[W2-1:XLEN];
      OpMulw:                      bus.out_result = {{HW{acc_q[HW-1]}}, acc_q[HW-1:0]};
      default:                     bus.out_result = '0;
    endcase
  end
endmodule

// File: tb/tb_ysyx_041461_booth_iter_mul.sv
// Self-checking bench for the Booth multiplier: directed corner cases plus randomized ops
// against a plain 128-bit arithmetic reference.
module tb_ysyx_041461_booth_iter_mul;
  localparam int unsigned XLEN = 64;
  localparam int LatFull = XLEN / 2 + 1;
  localparam int LatWord = XLEN / 4 + 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ysyx_041461_booth_iter_mul_if #(.XLEN(XLEN)) bus ();

  ysyx_041461_booth_iter_mul #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [31:0]  lo;
    ea = '0;
    eb = '0;
    case (op)
      3'd0, 3'd1: begin ea = {{64{a[63]}}, a}; eb = {{64{b[63]}}, b}; end
      3'd2:       begin ea = {{64{a[63]}}, a}; eb = {64'd0, b}; end
      3'd3:       begin ea = {64'd0, a};       eb = {64'd0, b}; end
      3'd4:       begin ea = {{96{a[31]}}, a[31:0]}; eb = {{96{b[31]}}, b[31:0]}; end
      default:    return 64'd0;
    endcase
    p = ea * eb;
    lo = p[31:0];
    case (op)
      3'd0:    return p[63:0];
      3'd4:    return {{32{lo[31]}}, lo};
      default: return p[127:64];
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = a;
    bus.in_src2  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_src1  = {$urandom, $urandom};
    bus.in_src2  = {$urandom, $urandom};
    bus.in_op    = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (exp_lat > 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, bus.out_result, exp_res);
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_ovld_after"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_rdy_after"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b);
    int lat;
    lat = (op == 3'd4) ? LatWord : ((op <= 3'd3) ? LatFull : 0);
    start_op(op, a, b);
    wait_done(tag, lat, ref_mul(op, a, b));
    consume(tag);
  endtask

  initial begin
    logic [63:0] held, a, b, pool [6];
    logic [2:0]  op;
    int          seen;
    checks   = 0;
    failures = 0;
    pool[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    pool[1] = 64'h8000_0000_0000_0000;
    pool[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    pool[3] = 64'd0;
    pool[4] = 64'h0000_0000_8000_0000;
    pool[5] = 64'd1;

    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.out_ready = 1'b0;
    #12;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_result", bus.out_result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mulhu_ones", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulh_min", 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    run_op("mul_m1", 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulhsu_m1", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulw", 3'd4, 64'hDEAD_0000_7FFF_FFFF, 64'h0000_0000_0000_0002);
    run_op("reserved", 3'd6, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);

    // Backpressure: result held, no new accept while in_valid stays high.
    start_op(3'd0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    wait_done("bp", LatFull, ref_mul(3'd0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210));
    held = bus.out_result;
    @(negedge clk);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_ovld", 64'(bus.out_valid), 64'd1);
      check("bp_hold", bus.out_result, held);
      check("bp_rdy", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    consume("bp");

    // Flush mid-CALC, then an op must still complete normally.
    start_op(3'd0, 64'd11, 64'd13);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_ovld", 64'(bus.out_valid), 64'd0);
    check("flush_rdy", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    run_op("after_flush", 3'd0, 64'd3, 64'd7);

    // in_valid alongside flush must not be accepted.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_blocks_accept", 64'(bus.in_ready), 64'd1);

    // Flush together with out_ready in DONE.
    start_op(3'd1, 64'd5, 64'd9);
    wait_done("flush_done", LatFull, 64'd0);
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check("flush_done_ovld", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-CALC.
    start_op(3'd3, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_ovld", 64'(bus.out_valid), 64'd0);
    check("rst_rdy", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 3'd3, 64'h8000_0000_0000_0000, 64'd4);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : {$urandom, $urandom};
      b  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : {$urandom, $urandom};
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
